// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared definitions for the iterative multiply/divide unit:
//               operation encodings, FSM state type and default width.
//               Divide support is compiled in with the MULDIV_DIV_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : One radix-2 iteration of the multiply/divide datapath.
//               Multiply: shift-add on a 2*WIDTH accumulator whose low half
//               holds the remaining multiplier bits.
//               Divide (only when MULDIV_DIV_EN is defined): restoring
//               shift-subtract, quotient in the low half, partial remainder
//               in the high half.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   operand_i,
  input  logic               is_div_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;

  // Multiply step: conditionally add the multiplicand to the high half,
  // then shift the whole accumulator right, keeping the carry.
  always_comb begin
    w_mul_sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
               + (acc_i[0] ? {1'b0, operand_i} : {(WIDTH+1){1'b0}});
    w_mul_next = {w_mul_sum, acc_i[WIDTH-1:1]};
  end

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]     w_div_top;
  logic [WIDTH:0]     w_div_diff;
  logic [2*WIDTH-1:0] w_div_next;

  // Divide step: shift left one bit, trial-subtract the divisor from the
  // widened high half and keep the difference only when it did not borrow.
  always_comb begin
    w_div_top  = acc_i[2*WIDTH-1:WIDTH-1];
    w_div_diff = w_div_top - {1'b0, operand_i};
    if (w_div_diff[WIDTH]) begin
      w_div_next = {w_div_top[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
    end else begin
      w_div_next = {w_div_diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
    end
  end

  // Select the step result for the active operation.
  always_comb begin
    acc_o = is_div_i ? w_div_next : w_mul_next;
  end
`else
  logic w_unused_div;

  // Only multiply exists in this build; the mode input is ignored.
  always_comb begin
    w_unused_div = is_div_i;
    acc_o        = w_mul_next;
  end
`endif

endmodule : muldiv_step
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative multiply/divide unit owning the HI/LO registers.
//               MULT/MULTU/DIV/DIVU take WIDTH+2 cycles from start to done;
//               mthi/mtlo style direct writes are accepted only when idle.
//               Divide ops are supported only when MULDIV_DIV_EN is defined;
//               otherwise a divide start is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hilo_we,
  input  logic             hilo_sel,
  input  logic [WIDTH-1:0] hilo_wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               dbz_q, dbz_d;
  logic [WIDTH-1:0]   a_orig_q, a_orig_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               w_op_ok;
  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH-1:0] w_step_acc;
  logic [2*WIDTH-1:0] w_prod;

  // Single radix-2 iteration; the FSM feeds it the current accumulator.
  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .is_div_i  (is_div_q),
    .acc_o     (w_step_acc)
  );

  // Operand preparation: which ops are accepted and the magnitudes/signs.
  always_comb begin
`ifdef MULDIV_DIV_EN
    w_op_ok  = 1'b1;
`else
    w_op_ok  = ~op[1];
`endif
    w_signed = ~op[0];
    w_a_neg  = w_signed & a[WIDTH-1];
    w_b_neg  = w_signed & b[WIDTH-1];
    w_a_mag  = w_a_neg ? -a : a;
    w_b_mag  = w_b_neg ? -b : b;
    w_prod   = neg_q ? -acc_q : acc_q;
  end

  // Next-state and datapath control for the IDLE/RUN/FIX sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dbz_d     = dbz_q;
    a_orig_d  = a_orig_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && w_op_ok) begin
          // Multiply keeps the multiplier in the low half and adds the
          // multiplicand; divide starts with the dividend in the low half.
          is_div_d  = op[1];
          neg_d     = w_a_neg ^ w_b_neg;
          rem_neg_d = w_a_neg;
          dbz_d     = (b == '0);
          a_orig_d  = a;
          cnt_d     = '0;
          if (op[1]) begin
            acc_d  = {{WIDTH{1'b0}}, w_a_mag};
            opnd_d = w_b_mag;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, w_b_mag};
            opnd_d = w_a_mag;
          end
          state_d = RUN;
        end else if (hilo_we && !start) begin
          // A start, even an unsupported one, suppresses the direct write.
          if (hilo_sel) begin
            hi_d = hilo_wd;
          end else begin
            lo_d = hilo_wd;
          end
        end
      end

      RUN: begin
        acc_d = w_step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        if (is_div_q) begin
          if (dbz_q) begin
            lo_d = '1;
            hi_d = a_orig_q;
          end else begin
            // Quotient sign from the operand signs, remainder follows the
            // dividend; the most-negative / -1 case wraps to itself.
            lo_d = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            hi_d = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
          end
        end else begin
          hi_d = w_prod[2*WIDTH-1:WIDTH];
          lo_d = w_prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and HI/LO registers; reset aborts any operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dbz_q     <= 1'b0;
      a_orig_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dbz_q     <= dbz_d;
      a_orig_q  <= a_orig_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  // Status and register read-out.
  always_comb begin
    busy = (state_q != IDLE);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
    rd   = hilo_sel ? hi_q : lo_q;
  end

endmodule : muldiv_unit
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Scoreboard bench for muldiv_unit. Stimulus pushes expected
//               HI/LO and completion cycle; a monitor thread pops on done.
//               Divide expectations follow MULDIV_DIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         hilo_we = 1'b0;
  logic         hilo_sel = 1'b0;
  logic [W-1:0] hilo_wd = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [W-1:0] rd;

  typedef struct {
    logic [63:0] res;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] cur_hi = '0;
  logic [31:0] cur_lo = '0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hilo_we  (hilo_we),
    .hilo_sel (hilo_sel),
    .hilo_wd  (hilo_wd),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .rd       (rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic op_supported(input logic [1:0] o);
`ifdef MULDIV_DIV_EN
    return 1'b1;
`else
    return ~o[1];
`endif
  endfunction

  // Reference results in plain 64-bit arithmetic: {HI, LO}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p, q, r;
    logic [63:0] ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      2'b00: begin p = sx * sy; return p; end
      2'b01: return ux * uy;
      2'b10: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        return {32'(ux % uy), 32'(ux / uy)};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] corners [0:5];
    corners[0] = 32'h0;          corners[1] = 32'h1;
    corners[2] = 32'hFFFFFFFF;   corners[3] = 32'h80000000;
    corners[4] = 32'h7FFFFFFF;   corners[5] = 32'h2;
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return $urandom_range(0, 1000);
      2: return corners[$urandom_range(0, 5)];
      default: return -$urandom_range(1, 1000);
    endcase
  endfunction

  // Drive one start at a negedge; ends at the following negedge.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic ok;
    exp_t e;
    ok = op_supported(o);
    start = 1'b1; op = o; a = x; b = y;
    if (ok) begin
      e.res = model(o, x, y);
      e.due = cyc + LAT;
      sb_q.push_back(e);
      cur_hi = e.res[63:32];
      cur_lo = e.res[31:0];
    end
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, ok);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 4 * LAT) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) check("busy_timeout", busy, 0);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    issue(o, x, y);
    wait_idle();
    check("hold_hi", hi, cur_hi);
    check("hold_lo", lo, cur_lo);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!reset && done) begin
          exp_t e;
          if (sb_q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sb_q.pop_front();
            check("sb_hi", hi, e.res[63:32]);
            check("sb_lo", lo, e.res[31:0]);
            check("sb_done_cycle", 64'(cyc), 64'(e.due));
          end
        end
      end
    join_none

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_rd", rd, 0);
    reset = 1'b0;
    @(negedge clk);

    run_op(OP_MULT, 32'hFFFFFFFD, 32'd5);
    check("mult_neg_hi", hi, 32'hFFFFFFFF);
    check("mult_neg_lo", lo, 32'hFFFFFFF1);
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("multu_max_hi", hi, 32'hFFFFFFFE);
    check("multu_max_lo", lo, 32'h00000001);
`ifdef MULDIV_DIV_EN
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2);
    check("div_neg_lo", lo, 32'hFFFFFFFD);
    check("div_neg_hi", hi, 32'hFFFFFFFF);
    run_op(OP_DIVU, 32'd7, 32'd0);
    check("divu_zero_lo", lo, 32'hFFFFFFFF);
    check("divu_zero_hi", hi, 32'd7);
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    check("div_ovf_lo", lo, 32'h80000000);
    check("div_ovf_hi", hi, 32'd0);
`else
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
    repeat (3) @(negedge clk);
    check("div_off_busy", busy, 0);
    check("div_off_hi", hi, 32'hFFFFFFFE);
    check("div_off_lo", lo, 32'h00000001);
`endif

    // Restart and direct write while busy are both ignored.
    issue(OP_MULT, 32'd2, 32'd3);
    repeat (9) @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    hilo_we = 1'b1; hilo_sel = 1'b0; hilo_wd = 32'hA5A5A5A5;
    @(negedge clk);
    hilo_we = 1'b0;
    check("still_busy", busy, 1);
    wait_idle();
    check("busy_ign_hi", hi, 32'd0);
    check("busy_ign_lo", lo, 32'd6);

    // Start with a simultaneous direct write: the write is dropped.
    hilo_we = 1'b1; hilo_sel = 1'b0; hilo_wd = 32'h12345678;
    issue(OP_MULTU, 32'd1000, 32'd1000);
    hilo_we = 1'b0;
    check("we_dropped_lo", lo, 32'd6);
    wait_idle();
    check("start_wins_lo", lo, 32'd1000000);

    // Reset mid-operation.
`ifdef MULDIV_DIV_EN
    issue(OP_DIVU, 32'd1000, 32'd7);
`else
    issue(OP_MULTU, 32'd1000, 32'd7);
`endif
    repeat (18) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_hi", hi, 0);
    check("mid_rst_lo", lo, 0);
    sb_q.delete();
    cur_hi = '0;
    cur_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_op(OP_MULTU, 32'd6, 32'd7);
    check("after_rst_lo", lo, 32'd42);
    check("after_rst_hi", hi, 32'd0);

    // Randomized back-to-back ops with occasional direct writes.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  o;
      logic [31:0] x, y, d;
      logic        s;
      o = 2'($urandom_range(0, 3));
      x = pick();
      y = pick();
      run_op(o, x, y);
      if (i % 4 == 3) begin
        s = 1'($urandom_range(0, 1));
        d = $urandom;
        hilo_we = 1'b1; hilo_sel = s; hilo_wd = d;
        @(negedge clk);
        hilo_we = 1'b0;
        if (s) cur_hi = d; else cur_lo = d;
        check("mt_hi", hi, cur_hi);
        check("mt_lo", lo, cur_lo);
        check("mt_rd", rd, s ? cur_hi : cur_lo);
      end
    end

    repeat (LAT + 10) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_muldiv_unit
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit that owns the HI/LO special registers for the MIPS core. It consumes operands from the register-file read ports (`srca`/`writedata`) when the decoder issues `mult`/`multu`/`div`/`divu`. It produces HI/LO for `mfhi`/`mflo`, replacing the single-cycle `*` in the ALU and the standalone HI/LO register file. While an operation runs it asserts `busy`; the controller stalls the PC on any HI/LO access until it clears.

## Interface
Parameters:
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk`, in, 1: clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: issue request; sampled on `clk` rising edge.
- `op`, in, 2: operation. 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`, in, `WIDTH`: rs operand, the multiplicand or dividend.
- `b`, in, `WIDTH`: rt operand, the multiplier or divisor.
- `hilo_we`, in, 1: direct write (`mthi`/`mtlo`).
- `hilo_sel`, in, 1: 1 selects HI, 0 selects LO; used for both the write and `rd`.
- `hilo_wd`, in, `WIDTH`: direct write data.
- `busy`, out, 1: operation in progress.
- `done`, out, 1: one-cycle pulse when the result is committed.
- `hi`, out, `WIDTH`: HI register.
- `lo`, out, `WIDTH`: LO register.
- `rd`, out, `WIDTH`: `hilo_sel ? hi : lo`; combinational.

## Operation
- FSM states:
  - IDLE: on `start`, latch magnitudes of `a`/`b` (signed ops take absolute value, unsigned ops pass through). Latch result signs, clear the counter, go to RUN.
  - RUN: one radix-2 step per cycle for exactly `WIDTH` cycles, then go to FIX.
    - Multiply: shift-add into a 2·`WIDTH` accumulator.
    - Divide: restoring shift-subtract; the quotient builds in the low half and the remainder in the high half.
  - FIX: apply signs, write HI/LO, pulse `done`, go to IDLE.
- Sign rules:
  - Signed product is negated if `a`, `b` signs differ.
  - Signed quotient is negated if signs differ.
  - Remainder takes the sign of the dividend.
- Results: MULT/MULTU give HI = product[2W-1:W] and LO = product[W-1:0]. DIV/DIVU give LO = quotient and HI = remainder.
- Divide by zero (signed or unsigned): LO = all ones, HI = `a` (original, unmodified). It still takes the full latency.
- Signed overflow, 0x80000000 / -1: LO = 0x80000000, HI = 0.
- `start` while `busy` is ignored; the operation in flight is unaffected.
- `hilo_we` is honoured only in IDLE without `start`.
  - Simultaneous `start` and `hilo_we` in IDLE: `start` wins and the write is dropped.
  - `hilo_we` while busy is dropped.
- HI/LO hold their value between operations; they change only in FIX or on an honoured direct write.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, state IDLE, counter 0.
- `reset` mid-operation aborts immediately; no result is written.
- `start` sampled at edge 0:
  - `busy`=1 during cycles 1..`WIDTH`+1.
  - HI/LO are updated at the edge ending cycle `WIDTH`+1.
  - `done`=1 and `busy`=0 in cycle `WIDTH`+2; this is 34 cycles for `WIDTH`=32.
- A new `start` is accepted in the `done` cycle, giving back-to-back throughput of one operation per `WIDTH`+2 cycles.
- Direct write is visible on `hi`/`lo`/`rd` the cycle after the edge.

## Configuration
- `MULDIV_DIV_EN` defined: all four ops are supported.
- `MULDIV_DIV_EN` undefined: divide datapath removed. `start` with `op[1]`=1 is ignored entirely: no `busy`, no `done`, HI/LO unchanged. MULT/MULTU are unaffected.

## Structure
- Package `muldiv_pkg`:
  - op encodings `OP_MULT`/`OP_MULTU`/`OP_DIV`/`OP_DIVU`.
  - state enum `IDLE`/`RUN`/`FIX`.
  - default `WIDTH`.
- One sub-module, `muldiv_step`: combinational single-iteration datapath. It takes the accumulator, operand and mode, and returns the next accumulator. The parent holds the FSM, counter, sign logic and HI/LO registers.

## Test plan
- MULT a=0xFFFFFFFD (-3), b=5 -> `done` in cycle 34, HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also DIVU a=7, b=0 -> LO=0xFFFFFFFF, HI=7.
- DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0. With `MULDIV_DIV_EN` undefined, the same `start` produces no `busy` and leaves HI/LO unchanged.
- `start` again at cycle 10 of a running MULT (a=2, b=3), plus `hilo_we` at cycle 12 -> both ignored; HI=0, LO=6. Then `start` together with `hilo_we` in IDLE -> the operation runs and the write is dropped.
- `reset` pulse at cycle 20 of a DIVU -> `busy`/`done`/HI/LO=0 immediately. A fresh MULTU 6×7 then gives LO=42 in cycle 34 after its `start`.
